// File: rtl/clip_ctrl_pkg.sv
// Shared types and defaults for the two-clip record/play controller.
package clip_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic CLIP_A = 1'b0;
  localparam logic CLIP_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    REC,
    PLAY
  } clip_state_t;

endpackage

// File: rtl/button_debounce.sv
// Debounces one synchronized button level and emits a one-cycle event on each accepted press.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_evt
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_d;
  logic             r_evt;

  // Level flips only after raw has disagreed for a full run of cycles; any agreement restarts it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_evt     <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_evt     <= r_level & ~r_level_d;
      if (raw != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= raw;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level     = r_level;
  assign press_evt = r_evt;

endmodule

// File: rtl/clip_record_controller.sv
// Record/play controller for two audio clips sharing one sample memory.
module clip_record_controller
  import clip_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W          = ADDR_W_DEF,
  parameter int unsigned DATA_W          = DATA_W_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              record_s,
  input  logic              play_s,
  input  logic              clip_wr_s,
  input  logic              clip_rd_s,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] sample_in,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              recording,
  output logic              playing,
  output logic              done
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] OFF_LAST = '1;
  localparam logic [LEN_W-1:0]  LEN_FULL = {1'b1, {ADDR_W{1'b0}}};

  logic w_rec_level;
  logic w_rec_press;
  logic w_play_level;
  logic w_play_press;
  logic w_rec_evt;
  logic w_play_evt;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rec_db (
    .clock     (clock),
    .reset     (reset),
    .raw       (record_s),
    .level     (w_rec_level),
    .press_evt (w_rec_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_play_db (
    .clock     (clock),
    .reset     (reset),
    .raw       (play_s),
    .level     (w_play_level),
    .press_evt (w_play_press)
  );

  // A press only counts while the debounced button is still held.
  assign w_rec_evt  = w_rec_press & w_rec_level;
  assign w_play_evt = w_play_press & w_play_level;

  clip_state_t       r_state;
  clip_state_t       w_state_next;
  logic              r_clip;
  logic              w_clip_next;
  logic [ADDR_W-1:0] r_offset;
  logic [ADDR_W-1:0] w_offset_next;
  logic [LEN_W-1:0]  r_len      [2];
  logic [LEN_W-1:0]  w_len_next [2];
  logic [ADDR_W:0]   r_addr;
  logic [ADDR_W:0]   w_addr_next;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] w_wdata_next;
  logic              r_we;
  logic              w_we_next;
  logic              r_re;
  logic              w_re_next;
  logic              r_done;
  logic              w_done_next;
  logic              r_recording;
  logic              r_playing;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_clip      <= CLIP_A;
      r_offset    <= '0;
      r_len[0]    <= '0;
      r_len[1]    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_done      <= 1'b0;
      r_recording <= 1'b0;
      r_playing   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_clip      <= w_clip_next;
      r_offset    <= w_offset_next;
      r_len[0]    <= w_len_next[0];
      r_len[1]    <= w_len_next[1];
      r_addr      <= w_addr_next;
      r_wdata     <= w_wdata_next;
      r_we        <= w_we_next;
      r_re        <= w_re_next;
      r_done      <= w_done_next;
      r_recording <= (w_state_next == REC);
      r_playing   <= (w_state_next == PLAY);
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_clip_next   = r_clip;
    w_offset_next = r_offset;
    w_len_next[0] = r_len[0];
    w_len_next[1] = r_len[1];
    w_addr_next   = r_addr;
    w_wdata_next  = r_wdata;
    w_we_next     = 1'b0;
    w_re_next     = 1'b0;
    w_done_next   = 1'b0;

    case (r_state)
      IDLE: begin
        // Record has priority; playing an empty clip is silently ignored.
        if (w_rec_evt) begin
          w_clip_next   = clip_wr_s;
          w_offset_next = '0;
          w_state_next  = REC;
        end else if (w_play_evt && (r_len[clip_rd_s] != '0)) begin
          w_clip_next   = clip_rd_s;
          w_offset_next = '0;
          w_state_next  = PLAY;
        end
      end

      REC: begin
        // A stop press wins over a tick arriving in the same cycle.
        if (w_rec_evt) begin
          w_len_next[r_clip] = {1'b0, r_offset};
          w_done_next        = 1'b1;
          w_state_next       = IDLE;
        end else if (sample_tick) begin
          w_we_next    = 1'b1;
          w_addr_next  = {r_clip, r_offset};
          w_wdata_next = sample_in;
          if (r_offset == OFF_LAST) begin
            w_len_next[r_clip] = LEN_FULL;
            w_done_next        = 1'b1;
            w_state_next       = IDLE;
          end else begin
            w_offset_next = r_offset + ADDR_W'(1);
          end
        end
      end

      PLAY: begin
        if (w_play_evt) begin
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end else if (sample_tick) begin
          w_re_next   = 1'b1;
          w_addr_next = {r_clip, r_offset};
          if ({1'b0, r_offset} == (r_len[r_clip] - LEN_W'(1))) begin
            w_done_next  = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_offset_next = r_offset + ADDR_W'(1);
          end
        end
      end

      default: w_state_next = IDLE;
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_we;
  assign mem_re    = r_re;
  assign recording = r_recording;
  assign playing   = r_playing;
  assign done      = r_done;

endmodule

// File: tb/tb_clip_record_controller.sv
// Directed bench for clip_record_controller with a strobe scoreboard.
module tb_clip_record_controller;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEB    = 4;

  logic              clock;
  logic              reset;
  logic              record_s;
  logic              play_s;
  logic              clip_wr_s;
  logic              clip_rd_s;
  logic              sample_tick;
  logic [DATA_W-1:0] sample_in;
  logic [ADDR_W:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic              recording;
  logic              playing;
  logic              done;

  clip_record_controller #(
    .ADDR_W          (ADDR_W),
    .DATA_W          (DATA_W),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .record_s    (record_s),
    .play_s      (play_s),
    .clip_wr_s   (clip_wr_s),
    .clip_rd_s   (clip_rd_s),
    .sample_tick (sample_tick),
    .sample_in   (sample_in),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .recording   (recording),
    .playing     (playing),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic              we;
    logic              re;
    logic              dn;
    logic [ADDR_W:0]   addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic re, input logic dn,
                      input logic [ADDR_W:0] addr, input logic [DATA_W-1:0] data);
    exp_t e;
    e.we = we; e.re = re; e.dn = dn; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Hold the buttons long enough to debounce, then release and let the release settle.
  task automatic press(input logic rec, input logic ply, input int hold);
    record_s = rec;
    play_s   = ply;
    cycles(hold);
    record_s = 1'b0;
    play_s   = 1'b0;
    cycles(2 * DEB);
  endtask

  task automatic tick(input logic [DATA_W-1:0] d);
    sample_in   = d;
    sample_tick = 1'b1;
    cycles(1);
    sample_tick = 1'b0;
    cycles(1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_recording"}, 32'(recording), 32'd0);
    check({tag, "_playing"},   32'(playing),   32'd0);
    check({tag, "_we"},        32'(mem_we),    32'd0);
    check({tag, "_re"},        32'(mem_re),    32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_addr"},      32'(mem_addr),  32'd0);
    check({tag, "_wdata"},     32'(mem_wdata), 32'd0);
  endtask

  // Scoreboard: every strobe or done pulse must match the next queued expectation.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      check("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
      if (mem_we || mem_re || done) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", 32'({mem_we, mem_re, done}), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("strobe_we",   32'(mem_we), 32'(e.we));
          check("strobe_re",   32'(mem_re), 32'(e.re));
          check("strobe_done", 32'(done),   32'(e.dn));
          if (e.we || e.re) check("strobe_addr", 32'(mem_addr), 32'(e.addr));
          if (e.we) check("strobe_wdata", 32'(mem_wdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] smp [3];
    smp[0] = 8'h11; smp[1] = 8'h22; smp[2] = 8'h33;

    reset = 1'b0; record_s = 1'b0; play_s = 1'b0;
    clip_wr_s = 1'b0; clip_rd_s = 1'b0; sample_tick = 1'b0; sample_in = '0;
    cycles(3);
    check_idle_outputs("reset");
    reset = 1'b1;
    cycles(2);

    // Short press rejected, long press gives a single record event.
    press(1'b1, 1'b0, 3);
    cycles(4);
    check("short_press_recording", 32'(recording), 32'd0);
    press(1'b1, 1'b0, 10);
    check("long_press_recording", 32'(recording), 32'd1);
    push(1'b0, 1'b0, 1'b1, '0, '0);
    press(1'b1, 1'b0, 10);
    check("stop_empty_recording", 32'(recording), 32'd0);
    check("stop_empty_sb", 32'(sb.size()), 32'd0);

    // Record three samples into clip B, switch change mid-op ignored.
    clip_wr_s = 1'b1;
    press(1'b1, 1'b0, 10);
    check("recB_recording", 32'(recording), 32'd1);
    clip_wr_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 1'b0, 1'b0, 4'(8 + i), smp[i]);
      tick(smp[i]);
    end
    push(1'b0, 1'b0, 1'b1, '0, '0);
    press(1'b1, 1'b0, 10);
    check("recB_stopped", 32'(recording), 32'd0);
    check("recB_sb", 32'(sb.size()), 32'd0);

    // Play of empty clip A is ignored; clip B plays exactly three reads.
    clip_rd_s = 1'b0;
    press(1'b0, 1'b1, 10);
    check("playA_empty_playing", 32'(playing), 32'd0);
    clip_rd_s = 1'b1;
    press(1'b0, 1'b1, 10);
    check("playB_playing", 32'(playing), 32'd1);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, (i == 2), 4'(8 + i), '0);
    for (int i = 0; i < 5; i++) tick(8'hE0 + 8'(i));
    check("playB_ended", 32'(playing), 32'd0);
    check("playB_sb", 32'(sb.size()), 32'd0);

    // Fill clip A: auto-stop after the eighth write, extra ticks do nothing.
    press(1'b1, 1'b0, 10);
    check("recA_recording", 32'(recording), 32'd1);
    for (int i = 0; i < 8; i++) push(1'b1, 1'b0, (i == 7), 4'(i), 8'hA0 + 8'(i));
    for (int i = 0; i < 10; i++) tick(8'hA0 + 8'(i));
    check("recA_full_stopped", 32'(recording), 32'd0);
    check("recA_sb", 32'(sb.size()), 32'd0);

    // Full clip A plays back all eight locations.
    clip_rd_s = 1'b0;
    press(1'b0, 1'b1, 10);
    check("playA_playing", 32'(playing), 32'd1);
    for (int i = 0; i < 8; i++) push(1'b0, 1'b1, (i == 7), 4'(i), '0);
    for (int i = 0; i < 9; i++) tick(8'h00);
    check("playA_ended", 32'(playing), 32'd0);
    check("playA_sb", 32'(sb.size()), 32'd0);

    // Simultaneous presses: record wins; play during REC ignored.
    press(1'b1, 1'b1, 10);
    check("both_recording", 32'(recording), 32'd1);
    check("both_playing", 32'(playing), 32'd0);
    press(1'b0, 1'b1, 10);
    check("play_in_rec_recording", 32'(recording), 32'd1);
    check("play_in_rec_sb", 32'(sb.size()), 32'd0);

    // Reset mid-record clears everything including clip lengths.
    push(1'b1, 1'b0, 1'b0, 4'd0, 8'h5A);
    sample_in = 8'h5A;
    sample_tick = 1'b1;
    cycles(1);
    sample_tick = 1'b0;
    @(negedge clock);
    #1;
    reset = 1'b0;
    cycles(1);
    check_idle_outputs("midrec_reset");
    reset = 1'b1;
    clip_rd_s = 1'b1;
    press(1'b0, 1'b1, 10);
    check("post_reset_playB", 32'(playing), 32'd0);
    clip_rd_s = 1'b0;
    press(1'b0, 1'b1, 10);
    check("post_reset_playA", 32'(playing), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
